// File: rtl/shift_add_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Width of the iteration counter: enough to count 0..N-1, never narrower than 1.
  function automatic int cnt_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/NBitFullAdder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module NBitFullAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] c;

  assign c[0] = Cin;

  // Carry ripples from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier, one shift-and-add step per clock.
// Optional build macro SHIFT_ADD_ZERO_BYPASS_EN: a zero operand skips
// straight to DONE with a zero product.
module shift_add_multiplier
  import shift_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_w(N);

  mul_state_t     state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic [2*N:0]   acc_wide;
  logic [2*N-1:0] acc_shift;

  // Addend is the multiplicand only when the current multiplier bit is set.
  assign add_b = mcand_q & {N{acc_q[0]}};

  NBitFullAdder #(.N(N)) u_add (
    .A    (acc_q[2*N-1:N]),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Carry enters at the MSB of a 2N+1-bit value which is then shifted right
  // by one; written this way so N=1 needs no empty slice.
  assign acc_wide  = {add_cout, add_sum, acc_q[N-1:0]};
  assign acc_shift = acc_wide[2*N:1];

  // Next-state computation for FSM, counter, accumulator and result.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{N{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            state_d   = DONE;
            product_d = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d   = DONE;
          product_d = acc_shift;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=8) against a plain a*b model.
// Expectations follow SHIFT_ADD_ZERO_BYPASS_EN when it is defined.
module tb_shift_add_multiplier;

  localparam int N = 8;
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           ready, busy, done;
  logic [2*N-1:0] product;

  int vectors = 0;
  int miscompares = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: drive start, watch busy/done, compare against ta*tb_.
  // inj > 0 pulses a stray start (7x7) at that sample index.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input int inj, input string tag);
    logic [2*N-1:0] exp_p;
    int exp_lat, exp_busy, lat, bcnt;
    bit zero;
    exp_p    = (2*N)'(ta) * (2*N)'(tb_);
    zero     = (ta == 0) || (tb_ == 0);
    exp_lat  = (BYP && zero) ? 1 : N + 1;
    exp_busy = (BYP && zero) ? 0 : N;
    chk({tag, ".ready_in"}, 32'(ready), 32'd1);
    start = 1'b1; a = ta; b = tb_;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= N + 4; i++) begin
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
      if (inj != 0 && i == inj) begin start = 1'b1; a = 8'd7; b = 8'd7; end
      tick();
      start = 1'b0;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    chk({tag, ".product"}, 32'(product), 32'(exp_p));
    tick();
    chk({tag, ".ready_after"}, 32'(ready), 32'd1);
    chk({tag, ".done_after"}, 32'(done), 32'd0);
    chk({tag, ".product_hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int dcnt;
    int d1, d2;
    bit hold_ok;
    logic [N-1:0] ra, rb;

    // Reset, then idle for 5 cycles.
    #12;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.product", 32'(product), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.ready", 32'(ready), 32'd1);
      chk("idle.busy", 32'(busy), 32'd0);
      chk("idle.done", 32'(done), 32'd0);
      chk("idle.product", 32'(product), 32'd0);
    end

    // Directed operands.
    run_op(8'd13, 8'd11, 0, "13x11");
    run_op(8'd255, 8'd255, 0, "255x255");
    run_op(8'd0, 8'd200, 0, "0x200");
    run_op(8'd200, 8'd0, 0, "200x0");
    run_op(8'd1, 8'd255, 0, "1x255");
    run_op(8'd128, 8'd2, 0, "128x2");

    // Stray start during RUN must be ignored.
    run_op(8'd13, 8'd11, 2, "13x11_inj");

    // Reset mid-operation: outputs clear at once and no done follows.
    run_op(8'd255, 8'd254, 0, "pre_rst");
    start = 1'b1; a = 8'd13; b = 8'd11;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("midrst.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.ready", 32'(ready), 32'd1);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.product", 32'(product), 32'd0);
    #3 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("midrst.no_done", 32'(dcnt), 32'd0);
    chk("midrst.idle", 32'(ready), 32'd1);

    // Back-to-back with start held high.
    start = 1'b1; a = 8'd3; b = 8'd5;
    tick();
    a = 8'd100; b = 8'd200;
    d1 = 0; d2 = 0; hold_ok = 1'b1;
    for (int i = 1; i <= 2 * N + 8; i++) begin
      if (done && d1 == 0) begin
        d1 = i;
        chk("b2b.first_product", 32'(product), 32'd15);
      end else if (done && d2 == 0) begin
        d2 = i;
        chk("b2b.second_product", 32'(product), 32'd20000);
      end else if (d1 != 0 && d2 == 0 && product !== 16'd15) begin
        hold_ok = 1'b0;
      end
      if (i == N + 3) start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("b2b.first_done", 32'(d1), 32'(N + 1));
    chk("b2b.second_done", 32'(d2), 32'(2 * N + 3));
    chk("b2b.hold15", 32'(hold_ok), 32'd1);
    repeat (3) tick();

    // Randomized operands checked against the plain product.
    for (int t = 0; t < 24; t++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (t % 8 == 3) ra = '0;
      if (t % 8 == 5) rb = {N{1'b1}};
      run_op(ra, rb, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
